// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: req/gnt/rvalid bus master with byte-lane steering and load extension.
// Define LSU_MISALIGN_SPLIT_EN to run bus-word-crossing accesses as two beats instead of rejecting them.
module lsu_mem_stage #(
  parameter int unsigned XLEN = 32,
  localparam int unsigned NBYTES = XLEN / 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        funct3M,
  input  logic [XLEN-1:0]   addrM,
  input  logic [XLEN-1:0]   wdataM,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   load_data,
  output logic              misalign_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [NBYTES-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned OFFW = $clog2(NBYTES);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam int unsigned LANES = 2 * NBYTES;
`else
  localparam int unsigned LANES = NBYTES;
`endif
  localparam int unsigned WIDEW = 8 * LANES;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
`ifdef LSU_MISALIGN_SPLIT_EN
    ISSUE2,
    WAIT2,
`endif
    DONE
  } state_t;

  state_t          state;
  logic            weQ;
  logic [2:0]      funct3Q;
  logic [OFFW-1:0] offQ;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic              splitQ;
  logic [XLEN-1:0]   addr2Q;
  logic [NBYTES-1:0] be2Q;
  logic [XLEN-1:0]   wdata2Q;
  logic [XLEN-1:0]   rdata1Q;
`endif

  logic [OFFW-1:0]  reqOff;
  logic [3:0]       reqSize;
  logic [4:0]       reqEnd;
  logic             reqCross;
  logic             reqIllegal;
  logic             reqErr;
  logic [XLEN-1:0]  reqBase;
  logic [LANES-1:0] reqBe;
  logic [WIDEW-1:0] reqWdata;

  // Request decode: lane offset, size, crossing and illegal-size detection.
  always_comb begin
    reqOff     = addrM[OFFW-1:0];
    reqSize    = 4'd1 << funct3M[1:0];
    reqEnd     = 5'(reqOff) + 5'(reqSize);
    reqCross   = reqEnd > 5'(NBYTES);
    reqIllegal = (funct3M == 3'b111) ||
                 ((XLEN == 32) && ((funct3M == 3'b011) || (funct3M == 3'b110)));
`ifdef LSU_MISALIGN_SPLIT_EN
    reqErr     = reqIllegal;
`else
    reqErr     = reqIllegal || reqCross;
`endif
    reqBase    = {addrM[XLEN-1:OFFW], OFFW'(0)};
    reqBe      = LANES'((16'd1 << reqSize) - 16'd1) << reqOff;
    reqWdata   = WIDEW'(wdataM) << {reqOff, 3'b000};
  end

  logic [WIDEW-1:0] rdWide;
  logic [XLEN-1:0]  ldRaw;
  logic [XLEN-1:0]  keep;
  logic             sgn;
  logic [XLEN-1:0]  ldResult;

  // Load assembly: beat-2 bytes sit above beat-1 bytes, then shift down by the lane offset and extend.
  always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
    rdWide = splitQ ? {mem_rdata, rdata1Q} : {XLEN'(0), mem_rdata};
`else
    rdWide = mem_rdata;
`endif
    ldRaw = XLEN'(rdWide >> {offQ, 3'b000});
    keep  = '1;
    sgn   = 1'b0;
    case (funct3Q[1:0])
      2'b00:   begin keep = XLEN'(8'hFF);         sgn = ldRaw[7];      end
      2'b01:   begin keep = XLEN'(16'hFFFF);      sgn = ldRaw[15];     end
      2'b10:   begin keep = XLEN'(32'hFFFF_FFFF); sgn = ldRaw[31];     end
      default: begin keep = '1;                   sgn = ldRaw[XLEN-1]; end
    endcase
    if (weQ)
      ldResult = '0;
    else
      ldResult = (ldRaw & keep) | ((!funct3Q[2] && sgn) ? ~keep : '0);
  end

  assign busy = !clr && (((state != IDLE) && (state != DONE)) ||
                         ((state == IDLE) && req_valid && !reqErr));
  assign misalign_err = !clr && (state == IDLE) && req_valid && reqErr;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      weQ       <= 1'b0;
      funct3Q   <= '0;
      offQ      <= '0;
      done      <= 1'b0;
      load_data <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      splitQ    <= 1'b0;
      addr2Q    <= '0;
      be2Q      <= '0;
      wdata2Q   <= '0;
      rdata1Q   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && !reqErr) begin
            weQ       <= req_we;
            funct3Q   <= funct3M;
            offQ      <= reqOff;
            mem_req   <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= reqBase;
            mem_be    <= reqBe[NBYTES-1:0];
            mem_wdata <= reqWdata[XLEN-1:0];
`ifdef LSU_MISALIGN_SPLIT_EN
            splitQ    <= reqCross;
            addr2Q    <= reqBase + XLEN'(NBYTES);
            be2Q      <= reqBe[LANES-1:NBYTES];
            wdata2Q   <= reqWdata[WIDEW-1:XLEN];
`endif
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (splitQ) begin
              rdata1Q   <= mem_rdata;
              mem_req   <= 1'b1;
              mem_addr  <= addr2Q;
              mem_be    <= be2Q;
              mem_wdata <= wdata2Q;
              state     <= ISSUE2;
            end else begin
              done      <= 1'b1;
              load_data <= ldResult;
              state     <= DONE;
            end
`else
            done      <= 1'b1;
            load_data <= ldResult;
            state     <= DONE;
`endif
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        ISSUE2: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT2;
          end
        end
        WAIT2: begin
          if (mem_rvalid) begin
            done      <= 1'b1;
            load_data <= ldResult;
            state     <= DONE;
          end
        end
`endif
        DONE: begin
          load_data <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage at XLEN=32: vector table for aligned accesses plus hand-written corner sequences.
module tb_lsu_mem_stage;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            clr;
  logic            req_valid;
  logic            req_we;
  logic [2:0]      funct3M;
  logic [XLEN-1:0] addrM;
  logic [XLEN-1:0] wdataM;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] load_data;
  logic            misalign_err;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  lsu_mem_stage #(.XLEN(XLEN)) dut (
    .clk(clk),
    .clr(clr),
    .req_valid(req_valid),
    .req_we(req_we),
    .funct3M(funct3M),
    .addrM(addrM),
    .wdataM(wdataM),
    .busy(busy),
    .done(done),
    .load_data(load_data),
    .misalign_err(misalign_err),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_be(mem_be),
    .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] expAddr;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic [31:0] expLoad;
    string       name;
  } vec_t;

  vec_t vecs[9];

  // Request in one cycle, grant after gntDelay extra ISSUE cycles, rvalid the cycle after grant.
  task automatic runAccess(input vec_t v, input int gntDelay);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = v.we;
    funct3M   = v.f3;
    addrM     = v.addr;
    wdataM    = v.wdata;
    #1;
    chk({v.name, "_busy_req"}, busy, 1);
    chk({v.name, "_noerr"}, misalign_err, 0);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i <= gntDelay; i++) begin
      chk({v.name, "_req"}, mem_req, 1);
      chk({v.name, "_we"}, mem_we, v.we);
      chk({v.name, "_addr"}, mem_addr, v.expAddr);
      chk({v.name, "_be"}, mem_be, v.expBe);
      chk({v.name, "_wdata"}, mem_wdata, v.expWdata);
      chk({v.name, "_busy_issue"}, busy, 1);
      chk({v.name, "_done_early"}, done, 0);
      mem_gnt = (i == gntDelay);
      @(negedge clk);
    end
    mem_gnt = 1'b0;
    chk({v.name, "_req_drop"}, mem_req, 0);
    chk({v.name, "_busy_wait"}, busy, 1);
    mem_rvalid = 1'b1;
    mem_rdata  = v.rdata;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    chk({v.name, "_done"}, done, 1);
    chk({v.name, "_load"}, load_data, v.expLoad);
    chk({v.name, "_busy_done"}, busy, 0);
    @(negedge clk);
    chk({v.name, "_done_pulse"}, done, 0);
  endtask

  // Request that must be rejected in its own cycle with no bus activity.
  task automatic runReject(input string name, input logic [2:0] f3, input logic [31:0] addr);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    funct3M   = f3;
    addrM     = addr;
    wdataM    = '0;
    #1;
    chk({name, "_err"}, misalign_err, 1);
    chk({name, "_busy"}, busy, 0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk({name, "_err_pulse"}, misalign_err, 0);
    for (int i = 0; i < 3; i++) begin
      chk({name, "_noreq"}, mem_req, 0);
      chk({name, "_nodone"}, done, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    clr        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    funct3M    = '0;
    addrM      = '0;
    wdataM     = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    vecs[0] = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        32'h100, 4'b1111, 32'hDEADBEEF, 32'h0,        "sw"};
    vecs[1] = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80112233, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80, "lb"};
    vecs[2] = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80112233, 32'h100, 4'b1000, 32'h0,        32'h00000080, "lbu"};
    vecs[3] = '{1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0,        32'h100, 4'b1100, 32'h12340000, 32'h0,        "sh"};
    vecs[4] = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80112233, 32'h100, 4'b1100, 32'h0,        32'hFFFF8011, "lh"};
    vecs[5] = '{1'b0, 3'b101, 32'h100, 32'h0,        32'h80112233, 32'h100, 4'b0011, 32'h0,        32'h00002233, "lhu"};
    vecs[6] = '{1'b0, 3'b010, 32'h204, 32'h0,        32'hCAFEF00D, 32'h204, 4'b1111, 32'h0,        32'hCAFEF00D, "lw"};
    vecs[7] = '{1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0,        32'h100, 4'b0010, 32'h0000A500, 32'h0,        "sb"};
    vecs[8] = '{1'b0, 3'b000, 32'h0FD, 32'h0,        32'h12345678, 32'h0FC, 4'b0010, 32'h0,        32'h00000056, "lb_pos"};

    repeat (2) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_err", misalign_err, 0);
    chk("rst_load", load_data, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_busy", busy, 0);
    clr = 1'b0;

    foreach (vecs[i]) runAccess(vecs[i], 0);

    // Grant held off for 5 cycles: bus outputs and busy must hold.
    runAccess(vecs[0], 5);

    runReject("f3_111", 3'b111, 32'h100);
    runReject("ld_rv32", 3'b011, 32'h100);
    runReject("lwu_rv32", 3'b110, 32'h100);

`ifdef LSU_MISALIGN_SPLIT_EN
    // lw 0x0FE crossing a word: two beats, one done.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; funct3M = 3'b010; addrM = 32'h0FE; wdataM = '0;
    #1 chk("split_busy_req", busy, 1);
    chk("split_noerr", misalign_err, 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("split_b1_req", mem_req, 1);
    chk("split_b1_addr", mem_addr, 32'h0FC);
    chk("split_b1_be", mem_be, 4'b1100);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("split_b1_wait", mem_req, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'hBBAA0000;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    chk("split_b2_req", mem_req, 1);
    chk("split_b2_addr", mem_addr, 32'h100);
    chk("split_b2_be", mem_be, 4'b0011);
    chk("split_b2_busy", busy, 1);
    chk("split_b2_nodone", done, 0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("split_b2_busy_wait", busy, 1);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000DDCC;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    chk("split_done", done, 1);
    chk("split_load", load_data, 32'hDDCCBBAA);
    @(negedge clk);
    chk("split_done_pulse", done, 0);
`else
    runReject("misalign", 3'b010, 32'h0FE);
`endif

    // clr during WAIT: immediate IDLE, outputs cleared, later stray rvalid ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; funct3M = 3'b010; addrM = 32'h300; wdataM = 32'h55AA55AA;
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("clr_in_wait", busy, 1);
    clr = 1'b1;
    #1;
    chk("clr_req", mem_req, 0);
    chk("clr_we", mem_we, 0);
    chk("clr_addr", mem_addr, 0);
    chk("clr_be", mem_be, 0);
    chk("clr_wdata", mem_wdata, 0);
    chk("clr_done", done, 0);
    chk("clr_load", load_data, 0);
    chk("clr_busy", busy, 0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678; mem_gnt = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0; mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_done", done, 0);
      chk("stray_busy", busy, 0);
      chk("stray_req", mem_req, 0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
